// File: rtl/fetch_unit.sv
// SAP-1 instruction-fetch datapath: program counter, MAR, 16x8 program RAM and IR.
// Drives the shared W-bus from PC, RAM or IR operand and returns the opcode nibble.
module fetch_unit (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       CP,
    input  logic       EP,
    input  logic       Lm_n,
    input  logic       CE_n,
    input  logic       LI_n,
    input  logic       EI_n,
    input  logic       j,
    input  logic       HLT_E,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       bus_conflict,
    output logic [3:0] ins_out,
    output logic [3:0] pc,
    output logic [3:0] mar,
    output logic       halted,
    input  logic       prog_en,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data
);

    logic [3:0] pc_q, pc_d;
    logic [3:0] mar_q, mar_d;
    logic [7:0] ir_q, ir_d;
    logic       halted_q;
    logic [7:0] ram [16];

    logic frozen;
    logic load_en;
    logic ep_on, ce_on, ei_on;

    assign frozen  = halted_q | prog_en;
    // A halt request suppresses every register load on the edge that sets halted.
    assign load_en = ~frozen & ~HLT_E;

    assign ep_on = EP & ~frozen;
    assign ce_on = ~CE_n & ~frozen;
    assign ei_on = ~EI_n & ~frozen;

    always_comb begin
        bus_out = 8'h00;
        if (ep_on) begin
            bus_out = {4'h0, pc_q};
        end else if (ce_on) begin
            bus_out = ram[mar_q];
        end else if (ei_on) begin
            bus_out = {4'h0, ir_q[3:0]};
        end
    end

    assign bus_oe       = ep_on | ce_on | ei_on;
    assign bus_conflict = (ep_on & ce_on) | (ep_on & ei_on) | (ce_on & ei_on);

    always_comb begin
        pc_d  = pc_q;
        mar_d = mar_q;
        ir_d  = ir_q;
        if (load_en) begin
            if (j) begin
                pc_d = bus_in[3:0];
            end else if (CP) begin
                pc_d = pc_q + 4'd1;
            end
            if (!Lm_n) begin
                mar_d = bus_in[3:0];
            end
            if (!LI_n) begin
                ir_d = bus_in;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pc_q     <= 4'h0;
            mar_q    <= 4'h0;
            ir_q     <= 8'h00;
            halted_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mar_q <= mar_d;
            ir_q  <= ir_d;
            if (HLT_E) begin
                halted_q <= 1'b1;
            end
        end
    end

    // RAM contents survive reset; the only write path is program-load mode.
    always_ff @(posedge clk) begin
        if (prog_en && prog_we) begin
            ram[prog_addr] <= prog_data;
        end
    end

    assign ins_out = ir_q[7:4];
    assign pc      = pc_q;
    assign mar     = mar_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected values queued with stimulus, popped on sampling.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       CP, EP, Lm_n, CE_n, LI_n, EI_n, j, HLT_E;
    logic [7:0] bus_in, bus_out, ext_bus;
    logic       bus_oe, bus_conflict, halted;
    logic [3:0] ins_out, pc, mar;
    logic       prog_en, prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    // System-level bus resolution: DUT when driving, otherwise an external source.
    assign bus_in = bus_oe ? bus_out : ext_bus;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .clr_n(clr_n), .CP(CP), .EP(EP), .Lm_n(Lm_n), .CE_n(CE_n),
        .LI_n(LI_n), .EI_n(EI_n), .j(j), .HLT_E(HLT_E), .bus_in(bus_in),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_conflict(bus_conflict),
        .ins_out(ins_out), .pc(pc), .mar(mar), .halted(halted),
        .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        CP = 0; EP = 0; Lm_n = 1; CE_n = 1; LI_n = 1; EI_n = 1; j = 0; HLT_E = 0;
        ext_bus = 8'h00;
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
        prog_en = 1; prog_we = 1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 0;
    endtask

    task automatic test_reset();
        idle_ctrl();
        prog_en = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
        clr_n = 0;
        exp_q.push_back('{name: "rst_pc", val: 8'h00});
        exp_q.push_back('{name: "rst_mar", val: 8'h00});
        exp_q.push_back('{name: "rst_ins", val: 8'h00});
        exp_q.push_back('{name: "rst_oe", val: 8'h00});
        exp_q.push_back('{name: "rst_bus", val: 8'h00});
        exp_q.push_back('{name: "rst_conf", val: 8'h00});
        exp_q.push_back('{name: "rst_halt", val: 8'h00});
        #3;
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, pc} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, pc, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, mar} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, mar, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, ins_out} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, ins_out, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if ({7'h0, bus_oe} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_oe, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus_out !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_out, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if ({7'h0, bus_conflict} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_conflict, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if ({7'h0, halted} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, halted, e.val); end
        clr_n = 1;
    endtask

    // Two full T1..T3 fetches from addresses 0 and 1.
    task automatic test_fetch();
        logic [7:0] prog [2];
        prog[0] = 8'h4A;
        prog[1] = 8'h5C;
        prog_write(4'd0, prog[0]);
        prog_write(4'd1, prog[1]);
        prog_write(4'd2, 8'h99);
        prog_en = 0;
        for (int k = 0; k < 2; k++) begin
            idle_ctrl(); EP = 1; Lm_n = 0;
            exp_q.push_back('{name: "t1_bus", val: 8'(k)});
            exp_q.push_back('{name: "t1_mar", val: 8'(k)});
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (bus_out !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_out, e.val); end
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if ({4'h0, mar} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, mar, e.val); end
            idle_ctrl(); CP = 1;
            exp_q.push_back('{name: "t2_pc", val: 8'(k + 1)});
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if ({4'h0, pc} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, pc, e.val); end
            idle_ctrl(); CE_n = 0; LI_n = 0;
            exp_q.push_back('{name: "t3_bus", val: prog[k]});
            exp_q.push_back('{name: "t3_ins", val: {4'h0, prog[k][7:4]}});
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (bus_out !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_out, e.val); end
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if ({4'h0, ins_out} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, ins_out, e.val); end
        end
        idle_ctrl();
    endtask

    task automatic test_jump();
        idle_ctrl(); EI_n = 0; j = 1; CP = 1;
        exp_q.push_back('{name: "jmp_bus", val: 8'h0C});
        exp_q.push_back('{name: "jmp_pc", val: 8'h0C});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus_out !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_out, e.val); end
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, pc} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, pc, e.val); end
        idle_ctrl();
    endtask

    task automatic test_wrap();
        idle_ctrl(); j = 1; ext_bus = 8'hAF;
        exp_q.push_back('{name: "wrap_load", val: 8'h0F});
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, pc} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, pc, e.val); end
        idle_ctrl(); CP = 1;
        exp_q.push_back('{name: "wrap_pc", val: 8'h00});
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, pc} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, pc, e.val); end
        idle_ctrl();
    endtask

    task automatic test_conflict();
        idle_ctrl(); Lm_n = 0; ext_bus = 8'hF2;
        tick();
        idle_ctrl(); j = 1; ext_bus = 8'h03;
        tick();
        idle_ctrl(); CE_n = 0;
        exp_q.push_back('{name: "ram_read", val: 8'h99});
        exp_q.push_back('{name: "single_conf", val: 8'h00});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus_out !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_out, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if ({7'h0, bus_conflict} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_conflict, e.val); end
        EP = 1;
        exp_q.push_back('{name: "conf_flag", val: 8'h01});
        exp_q.push_back('{name: "conf_bus", val: 8'h03});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({7'h0, bus_conflict} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_conflict, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus_out !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_out, e.val); end
        idle_ctrl();
    endtask

    task automatic test_prog_guard();
        idle_ctrl();
        prog_en = 0; prog_we = 1; prog_addr = 4'd2; prog_data = 8'hFF;
        tick();
        prog_we = 0; CE_n = 0;
        exp_q.push_back('{name: "guard_ram", val: 8'h99});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus_out !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_out, e.val); end
        idle_ctrl();
    endtask

    task automatic test_reset_mid();
        idle_ctrl(); j = 1; LI_n = 0; ext_bus = 8'h37;
        tick();
        idle_ctrl();
        exp_q.push_back('{name: "mid_pc7", val: 8'h07});
        exp_q.push_back('{name: "mid_pc", val: 8'h00});
        exp_q.push_back('{name: "mid_ins", val: 8'h00});
        exp_q.push_back('{name: "mid_oe", val: 8'h00});
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, pc} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, pc, e.val); end
        #2 clr_n = 0;
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, pc} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, pc, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, ins_out} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, ins_out, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if ({7'h0, bus_oe} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_oe, e.val); end
        #1 clr_n = 1;
        CE_n = 0;
        exp_q.push_back('{name: "ram_kept", val: 8'h4A});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus_out !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_out, e.val); end
        idle_ctrl();
    endtask

    task automatic test_halt();
        idle_ctrl(); CP = 1;
        tick();
        idle_ctrl(); HLT_E = 1; CP = 1; Lm_n = 0; LI_n = 0; ext_bus = 8'hA5;
        exp_q.push_back('{name: "hlt_flag", val: 8'h01});
        exp_q.push_back('{name: "hlt_pc", val: 8'h01});
        exp_q.push_back('{name: "hlt_mar", val: 8'h00});
        exp_q.push_back('{name: "hlt_ins", val: 8'h00});
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if ({7'h0, halted} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, halted, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, pc} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, pc, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, mar} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, mar, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, ins_out} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, ins_out, e.val); end
        idle_ctrl(); EP = 1; CP = 1;
        exp_q.push_back('{name: "hlt_oe", val: 8'h00});
        exp_q.push_back('{name: "hlt_bus", val: 8'h00});
        exp_q.push_back('{name: "hlt_sticky", val: 8'h01});
        exp_q.push_back('{name: "hlt_pc_hold", val: 8'h01});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({7'h0, bus_oe} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_oe, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus_out !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, bus_out, e.val); end
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if ({7'h0, halted} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, halted, e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if ({4'h0, pc} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, pc, e.val); end
        idle_ctrl();
        clr_n = 0;
        exp_q.push_back('{name: "hlt_clr", val: 8'h00});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({7'h0, halted} !== e.val) begin n_err++; $display("FAIL %s got %h want %h", e.name, halted, e.val); end
        clr_n = 1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_jump();
        test_wrap();
        test_conflict();
        test_prog_guard();
        test_reset_mid();
        test_halt();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
